fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer for the MIPS pipeline.
- Owns the program counter and drives the instruction-memory request/acknowledge handshake.
- Arbitrates next-PC sources with priority exception > branch > sequential.
- Combines per-stage stall requests into the pipeline stall vector and flush.
- Sits between the IF stage, the instruction memory port, and the ID/EX/MEM hazard sources.

Parameters:
RESET_PC, 32'h00000000, PC loaded on reset.
TIMEOUT_CYCLES, 16, wait-cycle limit (used only with the optional feature).

Ports:
clk  in  1  clock
rst  in  1  reset (synchronous, active-high)
stall_req_id  in  1  ID-stage stall request
stall_req_ex  in  1  EX-stage stall request (multi-cycle ops)
stall_req_mem  in  1  MEM-stage stall request
branch_flag_i  in  1  branch taken, level, from ID
branch_target_i  in  32  branch target
excp_flag_i  in  1  exception/eret redirect, one-cycle pulse
excp_target_i  in  32  exception vector or EPC
imem_ack_i  in  1  instruction memory transfer complete
imem_data_i  in  32  instruction word, valid with ack
imem_req_o  out  1  fetch request
imem_addr_o  out  32  fetch address
pc_o  out  32  address of instruction presented on inst_o
inst_o  out  32  fetched instruction to IF/ID
inst_valid_o  out  1  inst_o valid
stall_o  out  6  stall vector: [0]pc [1]if [2]id [3]ex [4]mem [5]wb
flush_o  out  1  flush IF/ID..MEM/WB
fetch_err_o  out  1  fetch timeout pulse (optional feature)

Behaviour:
- Reset values (registered outputs):
  - state=RST; pc=RESET_PC; imem_addr_o=RESET_PC; pc_o=RESET_PC.
  - imem_req_o=0; inst_o=0; inst_valid_o=0; fetch_err_o=0.
  - pending-redirect flag cleared; discard flag cleared; wait counter=0.
- Reset mid-operation: any outstanding request is abandoned; the memory side must tolerate a request dropped before ack.
- States: RST, ISSUE, WAIT, HOLD.
  - RST -> ISSUE on the first clock with rst low.
  - ISSUE: if stall_o[1]=0, raise imem_req_o with imem_addr_o=next fetch address, then -> WAIT. Otherwise stay in ISSUE.
  - WAIT: imem_req_o and imem_addr_o held stable until an edge samples imem_ack_i=1; same-cycle ack allowed.
    - On ack: drop req. If the discard flag is set, clear it and -> ISSUE (no inst_valid_o).
    - Else, if stall_o[1]=0: latch inst_o, present pc_o=fetched address, pulse inst_valid_o for one cycle, pc<=fetched+4, -> ISSUE.
    - Else: latch inst_o into the hold register, -> HOLD.
  - HOLD: inst_valid_o=1 and inst_o/pc_o held while stall_o[1]=1. On the first cycle stall_o[1]=0, the instruction is consumed, pc<=addr+4, -> ISSUE.
- stall_o (combinational, highest source wins):
  - excp_flag_i -> 000000.
  - stall_req_mem -> 011111.
  - stall_req_ex -> 001111.
  - stall_req_id -> 000111.
  - state WAIT without ack -> 000011.
  - otherwise 000000.
- flush_o = excp_flag_i, combinational.
- Redirects:
  - excp_flag_i is always accepted; branch_flag_i is accepted only when stall_o[2]=0.
  - If both are present in the same cycle, the exception wins and the branch is ignored.
  - Target [1:0] forced to 00.
  - In ISSUE or HOLD: pc<=target next edge; HOLD instruction dropped (inst_valid_o deasserts); -> ISSUE.
  - In WAIT: request continues until ack; discard flag set; target stored in pending register (a later redirect overwrites it); the next ISSUE uses the pending target and clears it.
- Arithmetic: pc+4 modulo 2^32; 32'hFFFFFFFC wraps to 32'h00000000.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- When defined:
  - Wait counter increments each WAIT cycle without ack and clears on ack or on leaving WAIT.
  - When it reaches TIMEOUT_CYCLES: fetch_err_o pulses one cycle, imem_req_o drops for one cycle, FSM returns to ISSUE and reissues the same address. A pending redirect is preserved.
- When undefined: no counter; WAIT is unbounded; fetch_err_o tied 0.

Test Plan:
- Reset release, ack one cycle after each req -> addresses 0x0,0x4,0x8; inst_valid_o pulses with matching pc_o and imem_data_i.
- stall_req_ex held 3 cycles while in WAIT, ack arrives -> stall_o=001111; inst held in HOLD with inst_valid_o=1; next req is addr+4 only after stall clears.
- branch_flag_i target 0x400 during WAIT -> in-flight ack discarded (no inst_valid_o); next imem_addr_o=0x400.
- excp_flag_i (target 0x80000180) together with branch_flag_i (target 0x400) and stall_req_mem -> flush_o=1, stall_o=000000; next fetch at 0x80000180, branch ignored.
- PC at 0xFFFFFFFC, ack -> next fetch 0x00000000; branch target 0x403 -> fetch 0x400.
- FETCH_TIMEOUT_EN, ack withheld 16 cycles -> fetch_err_o pulse, req low one cycle, reissue same address; undefined build: req held indefinitely, fetch_err_o=0.

Source files
------------

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer for the MIPS pipeline.
// Owns the PC, runs the instruction-memory req/ack handshake, arbitrates
// next-PC sources (exception > branch > sequential) and builds the pipeline
// stall vector and flush.
// Optional feature macro: FETCH_TIMEOUT_EN (fetch timeout with reissue).
//
// Memory handshake: imem_req_o rises with imem_addr_o and both stay stable
// until a rising edge samples imem_ack_i=1 (ack may arrive in the same cycle
// req is first seen); imem_data_i is only meaningful in the ack cycle. A
// request may be withdrawn without ack (reset, or fetch timeout).
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_req_id,
    input  logic        stall_req_ex,
    input  logic        stall_req_mem,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    input  logic        excp_flag_i,
    input  logic [31:0] excp_target_i,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        inst_valid_o,
    output logic [5:0]  stall_o,
    output logic        flush_o,
    output logic        fetch_err_o
);

    typedef enum logic [1:0] {ST_RST, ST_ISSUE, ST_WAIT, ST_HOLD} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc;
    logic [31:0] pend_target;
    logic        pend_valid;
    logic        discard;
    logic        redirect;
    logic [31:0] redir_raw;
    logic [31:0] redir_target;
    logic [31:0] fetch_addr;
    logic        timeout;

    // A redirect parked during WAIT takes precedence over the sequential PC.
    assign fetch_addr = pend_valid ? pend_target : pc;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_RST;
        else     state <= state_nxt;
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RST:   state_nxt = ST_ISSUE;
            ST_ISSUE: if (!redirect && !stall_o[1]) state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (imem_ack_i) begin
                    if (discard || redirect || !stall_o[1]) state_nxt = ST_ISSUE;
                    else                                    state_nxt = ST_HOLD;
                end else if (timeout) begin
                    state_nxt = ST_ISSUE;
                end
            end
            ST_HOLD:  if (redirect || !stall_o[1]) state_nxt = ST_ISSUE;
            default:  state_nxt = ST_RST;
        endcase
    end

    // Combinational outputs: stall vector, flush and redirect selection.
    always_comb begin
        stall_o = 6'b000000;
        if (excp_flag_i)                        stall_o = 6'b000000;
        else if (stall_req_mem)                 stall_o = 6'b011111;
        else if (stall_req_ex)                  stall_o = 6'b001111;
        else if (stall_req_id)                  stall_o = 6'b000111;
        else if (state == ST_WAIT && !imem_ack_i) stall_o = 6'b000011;
        flush_o      = excp_flag_i;
        // A stalled ID stage cannot hand over its branch decision.
        redirect     = excp_flag_i || (branch_flag_i && !stall_o[2]);
        redir_raw    = excp_flag_i ? excp_target_i : branch_target_i;
        redir_target = redir_raw & ~32'h3;
    end

    // Fetch datapath: PC, request, delivered instruction and redirect bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc           <= RESET_PC;
            imem_req_o   <= 1'b0;
            imem_addr_o  <= RESET_PC;
            pc_o         <= RESET_PC;
            inst_o       <= 32'h0;
            inst_valid_o <= 1'b0;
            pend_valid   <= 1'b0;
            pend_target  <= RESET_PC;
            discard      <= 1'b0;
        end else begin
            inst_valid_o <= 1'b0;
            case (state)
                ST_ISSUE: begin
                    if (redirect) begin
                        pc         <= redir_target;
                        pend_valid <= 1'b0;
                    end else if (!stall_o[1]) begin
                        imem_req_o  <= 1'b1;
                        imem_addr_o <= fetch_addr;
                        pc          <= fetch_addr;
                        pend_valid  <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (imem_ack_i) begin
                        imem_req_o <= 1'b0;
                        if (redirect) begin
                            // The word just returned belongs to the old path.
                            pc         <= redir_target;
                            pend_valid <= 1'b0;
                            discard    <= 1'b0;
                        end else if (discard) begin
                            discard <= 1'b0;
                        end else begin
                            inst_o       <= imem_data_i;
                            pc_o         <= imem_addr_o;
                            inst_valid_o <= 1'b1;
                            if (!stall_o[1]) pc <= imem_addr_o + 32'd4;
                        end
                    end else begin
                        if (redirect) begin
                            discard     <= 1'b1;
                            pend_valid  <= 1'b1;
                            pend_target <= redir_target;
                        end
                        if (timeout) begin
                            // Abandoned request will never ack; keep any parked redirect.
                            imem_req_o <= 1'b0;
                            discard    <= 1'b0;
                        end
                    end
                end
                ST_HOLD: begin
                    if (redirect) begin
                        pc         <= redir_target;
                        pend_valid <= 1'b0;
                    end else if (!stall_o[1]) begin
                        pc <= pc_o + 32'd4;
                    end else begin
                        inst_valid_o <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef FETCH_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] wait_cnt;

    assign timeout = (state == ST_WAIT) && !imem_ack_i &&
                     (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

    // Count unacknowledged WAIT cycles; report a timeout for one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt    <= '0;
            fetch_err_o <= 1'b0;
        end else begin
            fetch_err_o <= timeout;
            if (state == ST_WAIT && !imem_ack_i && !timeout) wait_cnt <= wait_cnt + 1'b1;
            else                                              wait_cnt <= '0;
        end
    end
`else
    assign timeout     = 1'b0;
    assign fetch_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed, table-driven bench for fetch_ctrl. Each table row
// is one clock cycle: inputs driven after the falling edge, then the outputs
// (registered results of earlier edges, combinational stall/flush of this
// row) compared before the next rising edge.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_req_id = 1'b0, stall_req_ex = 1'b0, stall_req_mem = 1'b0;
    logic        branch_flag_i = 1'b0, excp_flag_i = 1'b0, imem_ack_i = 1'b0;
    logic [31:0] branch_target_i = '0, excp_target_i = '0, imem_data_i = '0;
    logic        imem_req_o, inst_valid_o, flush_o, fetch_err_o;
    logic [31:0] imem_addr_o, pc_o, inst_o;
    logic [5:0]  stall_o;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [31:0] D0 = 32'h2401_0000, D1 = 32'h2402_0001, D2 = 32'h2403_0002;
    localparam logic [31:0] D3 = 32'h2404_0003, D4 = 32'h8C41_0000, D5 = 32'h4200_0018;
    localparam logic [31:0] D6 = 32'h03E0_0008, D7 = 32'h2405_0005, D8 = 32'h1111_2222;
    localparam logic [31:0] D9 = 32'h2222_3333;
    localparam logic [31:0] EV = 32'h8000_0180;

    fetch_ctrl dut (
        .clk(clk), .rst(rst),
        .stall_req_id(stall_req_id), .stall_req_ex(stall_req_ex), .stall_req_mem(stall_req_mem),
        .branch_flag_i(branch_flag_i), .branch_target_i(branch_target_i),
        .excp_flag_i(excp_flag_i), .excp_target_i(excp_target_i),
        .imem_ack_i(imem_ack_i), .imem_data_i(imem_data_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .pc_o(pc_o),
        .inst_o(inst_o), .inst_valid_o(inst_valid_o), .stall_o(stall_o),
        .flush_o(flush_o), .fetch_err_o(fetch_err_o)
    );

    // Clock generation.
    always #5 clk = ~clk;

    typedef struct {
        logic        id, ex, mem;
        logic        br;
        logic [31:0] br_tgt;
        logic        ec;
        logic [31:0] ec_tgt;
        logic        ack;
        logic [31:0] data;
        logic        e_req;
        logic [31:0] e_addr, e_pc, e_inst;
        logic        e_valid;
        logic [5:0]  e_stall;
        logic        e_flush;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic id, input logic ex, input logic mem,
        input logic br, input logic [31:0] br_tgt,
        input logic ec, input logic [31:0] ec_tgt,
        input logic ack, input logic [31:0] data,
        input logic e_req, input logic [31:0] e_addr, input logic [31:0] e_pc,
        input logic [31:0] e_inst, input logic e_valid, input logic [5:0] e_stall,
        input logic e_flush);
        vec_t v;
        v.id = id; v.ex = ex; v.mem = mem; v.br = br; v.br_tgt = br_tgt;
        v.ec = ec; v.ec_tgt = ec_tgt; v.ack = ack; v.data = data;
        v.e_req = e_req; v.e_addr = e_addr; v.e_pc = e_pc; v.e_inst = e_inst;
        v.e_valid = e_valid; v.e_stall = e_stall; v.e_flush = e_flush;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        stall_req_id    = v.id;
        stall_req_ex    = v.ex;
        stall_req_mem   = v.mem;
        branch_flag_i   = v.br;
        branch_target_i = v.br_tgt;
        excp_flag_i     = v.ec;
        excp_target_i   = v.ec_tgt;
        imem_ack_i      = v.ack;
        imem_data_i     = v.data;
    endtask

    task automatic idle_inputs();
        drive(mk(0,0,0, 0,0, 0,0, 0,0, 0,0,0,0,0,6'b0,0));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".req"},   {31'b0, imem_req_o},   32'h0);
        chk({tag, ".addr"},  imem_addr_o,           32'h0);
        chk({tag, ".pc"},    pc_o,                  32'h0);
        chk({tag, ".inst"},  inst_o,                32'h0);
        chk({tag, ".valid"}, {31'b0, inst_valid_o}, 32'h0);
        chk({tag, ".err"},   {31'b0, fetch_err_o},  32'h0);
        chk({tag, ".stall"}, {26'b0, stall_o},      32'h0);
    endtask

    initial begin
        int req_hi;

        // ---------------- vector table ----------------
        //           id ex mem br tgt            ec tgt          ack data          req addr          pc_o          inst v stall      fl
        vecs.push_back(mk(0,0,0, 0,0,            0,0,            0,0,            0,32'h0,        32'h0,        32'h0,0,6'b000000,0)); // r0 RST
        vecs.push_back(mk(0,0,0, 0,0,            0,0,            0,0,            0,32'h0,        32'h0,        32'h0,0,6'b000000,0)); // r1 ISSUE
        vecs.push_back(mk(0,0,0, 0,0,            0,0,            0,0,            1,32'h0,        32'h0,        32'h0,0,6'b000011,0)); // r2 WAIT
        vecs.push_back(mk(0,0,0, 0,0,            0,0,            1,D0,           1,32'h0,        32'h0,        32'h0,0,6'b000000,0)); // r3 ack
        vecs.push_back(mk(0,0,0, 0,0,            0,0,            0,0,            0,32'h0,        32'h0,        D0,   1,6'b000000,0)); // r4
        vecs.push_back(mk(0,0,0, 0,0,            0,0,            0,0,            1,32'h4,        32'h0,        D0,   0,6'b000011,0)); // r5
        vecs.push_back(mk(0,0,0, 0,0,            0,0,            1,D1,           1,32'h4,        32'h0,        D0,   0,6'b000000,0)); // r6
        vecs.push_back(mk(0,0,0, 0,0,            0,0,            0,0,            0,32'h4,        32'h4,        D1,   1,6'b000000,0)); // r7
        vecs.push_back(mk(0,0,0, 0,0,            0,0,            1,D2,           1,32'h8,        32'h4,        D1,   0,6'b000000,0)); // r8 same-cycle ack
        vecs.push_back(mk(0,0,0, 0,0,            0,0,            0,0,            0,32'h8,        32'h8,        D2,   1,6'b000000,0)); // r9
        vecs.push_back(mk(0,1,0, 0,0,            0,0,            0,0,            1,32'hC,        32'h8,        D2,   0,6'b001111,0)); // r10 EX stall
        vecs.push_back(mk(0,1,0, 0,0,            0,0,            1,D3,           1,32'hC,        32'h8,        D2,   0,6'b001111,0)); // r11 ack -> HOLD
        vecs.push_back(mk(0,1,0, 0,0,            0,0,            0,0,            0,32'hC,        32'hC,        D3,   1,6'b001111,0)); // r12 HOLD
        vecs.push_back(mk(0,0,0, 0,0,            0,0,            0,0,            0,32'hC,        32'hC,        D3,   1,6'b000000,0)); // r13 consume
        vecs.push_back(mk(0,0,0, 0,0,            0,0,            0,0,            0,32'hC,        32'hC,        D3,   0,6'b000000,0)); // r14
        vecs.push_back(mk(0,0,0, 1,32'h400,      0,0,            0,0,            1,32'h10,       32'hC,        D3,   0,6'b000011,0)); // r15 branch in WAIT
        vecs.push_back(mk(0,0,0, 0,0,            0,0,            1,32'hDEADBEEF, 1,32'h10,       32'hC,        D3,   0,6'b000000,0)); // r16 discarded ack
        vecs.push_back(mk(0,0,0, 0,0,            0,0,            0,0,            0,32'h10,       32'hC,        D3,   0,6'b000000,0)); // r17
        vecs.push_back(mk(0,0,0, 0,0,            0,0,            1,D4,           1,32'h400,      32'hC,        D3,   0,6'b000000,0)); // r18
        vecs.push_back(mk(0,0,1, 1,32'h400,      1,EV,           0,0,            0,32'h400,      32'h400,      D4,   1,6'b000000,1)); // r19 excp+br+mem
        vecs.push_back(mk(0,0,0, 0,0,            0,0,            0,0,            0,32'h400,      32'h400,      D4,   0,6'b000000,0)); // r20
        vecs.push_back(mk(0,0,0, 0,0,            0,0,            1,D5,           1,EV,           32'h400,      D4,   0,6'b000000,0)); // r21
        vecs.push_back(mk(0,0,0, 1,32'hFFFFFFFC, 0,0,            0,0,            0,EV,           EV,           D5,   1,6'b000000,0)); // r22
        vecs.push_back(mk(0,0,0, 0,0,            0,0,            0,0,            0,EV,           EV,           D5,   0,6'b000000,0)); // r23
        vecs.push_back(mk(0,0,0, 0,0,            0,0,            1,D6,           1,32'hFFFFFFFC, EV,           D5,   0,6'b000000,0)); // r24
        vecs.push_back(mk(0,0,0, 0,0,            0,0,            0,0,            0,32'hFFFFFFFC, 32'hFFFFFFFC, D6,   1,6'b000000,0)); // r25
        vecs.push_back(mk(0,0,0, 0,0,            0,0,            1,D7,           1,32'h0,        32'hFFFFFFFC, D6,   0,6'b000000,0)); // r26 wrap
        vecs.push_back(mk(0,0,0, 1,32'h403,      0,0,            0,0,            0,32'h0,        32'h0,        D7,   1,6'b000000,0)); // r27 unaligned br
        vecs.push_back(mk(0,0,0, 0,0,            0,0,            0,0,            0,32'h0,        32'h0,        D7,   0,6'b000000,0)); // r28
        vecs.push_back(mk(1,0,0, 1,32'h800,      0,0,            0,0,            1,32'h400,      32'h0,        D7,   0,6'b000111,0)); // r29 br blocked
        vecs.push_back(mk(0,0,0, 0,0,            0,0,            1,D8,           1,32'h400,      32'h0,        D7,   0,6'b000000,0)); // r30
        vecs.push_back(mk(0,0,0, 0,0,            0,0,            0,0,            0,32'h400,      32'h400,      D8,   1,6'b000000,0)); // r31
        vecs.push_back(mk(0,0,0, 0,0,            0,0,            0,0,            1,32'h404,      32'h400,      D8,   0,6'b000011,0)); // r32
        vecs.push_back(mk(0,0,1, 0,0,            0,0,            1,D9,           1,32'h404,      32'h400,      D8,   0,6'b011111,0)); // r33 -> HOLD
        vecs.push_back(mk(0,0,1, 0,0,            1,32'hBFC00383, 0,0,            0,32'h404,      32'h404,      D9,   1,6'b000000,1)); // r34 excp in HOLD
        vecs.push_back(mk(0,0,0, 0,0,            0,0,            0,0,            0,32'h404,      32'h404,      D9,   0,6'b000000,0)); // r35
        vecs.push_back(mk(0,0,0, 0,0,            1,32'h100,      0,0,            1,32'hBFC00380, 32'h404,      D9,   0,6'b000000,1)); // r36 excp in WAIT
        vecs.push_back(mk(0,0,0, 1,32'h204,      0,0,            0,0,            1,32'hBFC00380, 32'h404,      D9,   0,6'b000011,0)); // r37 overwrite
        vecs.push_back(mk(0,0,0, 0,0,            0,0,            1,32'h55555555, 1,32'hBFC00380, 32'h404,      D9,   0,6'b000000,0)); // r38 discarded
        vecs.push_back(mk(0,0,0, 0,0,            0,0,            0,0,            0,32'hBFC00380, 32'h404,      D9,   0,6'b000000,0)); // r39
        vecs.push_back(mk(0,0,0, 0,0,            0,0,            0,0,            1,32'h204,      32'h404,      D9,   0,6'b000011,0)); // r40

        // ---------------- power-on reset ----------------
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk_reset_vals("por");

        // ---------------- table ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst = 1'b0;
            drive(vecs[i]);
            #1;
            chk($sformatf("r%0d.req", i),   {31'b0, imem_req_o},   {31'b0, vecs[i].e_req});
            chk($sformatf("r%0d.addr", i),  imem_addr_o,           vecs[i].e_addr);
            chk($sformatf("r%0d.pc", i),    pc_o,                  vecs[i].e_pc);
            chk($sformatf("r%0d.inst", i),  inst_o,                vecs[i].e_inst);
            chk($sformatf("r%0d.valid", i), {31'b0, inst_valid_o}, {31'b0, vecs[i].e_valid});
            chk($sformatf("r%0d.stall", i), {26'b0, stall_o},      {26'b0, vecs[i].e_stall});
            chk($sformatf("r%0d.flush", i), {31'b0, flush_o},      {31'b0, vecs[i].e_flush});
            chk($sformatf("r%0d.err", i),   {31'b0, fetch_err_o},  32'h0);
        end

        // ---------------- reset while a request is outstanding ----------------
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk_reset_vals("midrst");
        rst = 1'b0;

        // ---------------- ack withheld ----------------
        @(negedge clk);
        #1;
        chk("to.issue_req", {31'b0, imem_req_o}, 32'h0);
        @(negedge clk);
        #1;
        chk("to.req0", {31'b0, imem_req_o}, 32'h1);
        chk("to.addr0", imem_addr_o, 32'h0);
        req_hi = 0;
        for (int k = 1; k < 16; k++) begin
            @(negedge clk);
            #1;
            if (imem_req_o === 1'b1 && fetch_err_o === 1'b0) req_hi++;
        end
        chk("to.held15", req_hi, 15);
        @(negedge clk);
        #1;
`ifdef FETCH_TIMEOUT_EN
        chk("to.drop_req", {31'b0, imem_req_o},  32'h0);
        chk("to.err_pulse", {31'b0, fetch_err_o}, 32'h1);
        @(negedge clk);
        #1;
        chk("to.reissue_req", {31'b0, imem_req_o},  32'h1);
        chk("to.reissue_addr", imem_addr_o,         32'h0);
        chk("to.err_cleared", {31'b0, fetch_err_o}, 32'h0);
`else
        chk("to.still_req", {31'b0, imem_req_o},  32'h1);
        chk("to.no_err", {31'b0, fetch_err_o},    32'h0);
        req_hi = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            #1;
            if (imem_req_o === 1'b1 && fetch_err_o === 1'b0 && imem_addr_o === 32'h0) req_hi++;
        end
        chk("to.held_long", req_hi, 20);
`endif
        // Finally acknowledge and see the word delivered from address 0.
        @(negedge clk);
        imem_ack_i  = 1'b1;
        imem_data_i = 32'hCAFE_0001;
        @(negedge clk);
        idle_inputs();
        #1;
        chk("to.final_valid", {31'b0, inst_valid_o}, 32'h1);
        chk("to.final_pc", pc_o, 32'h0);
        chk("to.final_inst", inst_o, 32'hCAFE_0001);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
